// File: rtl/jogador_automatico_pkg.sv
// Shared definitions for the automatic player: state codes, the state type and
// the one-hot test used on the game's leds.
package jogador_automatico_pkg;

  localparam logic [3:0] OCIOSO     = 4'd0;
  localparam logic [3:0] ESPERA_LED = 4'd1;
  localparam logic [3:0] CAPTURA    = 4'd2;
  localparam logic [3:0] QUIETO     = 4'd3;
  localparam logic [3:0] PRESSIONA  = 4'd4;
  localparam logic [3:0] SOLTA      = 4'd5;
  localparam logic [3:0] FIM        = 4'd6;

  typedef enum logic [3:0] {
    EST_OCIOSO     = OCIOSO,
    EST_ESPERA_LED = ESPERA_LED,
    EST_CAPTURA    = CAPTURA,
    EST_QUIETO     = QUIETO,
    EST_PRESSIONA  = PRESSIONA,
    EST_SOLTA      = SOLTA,
    EST_FIM        = FIM
  } estado_t;

  function automatic logic eh_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/jogador_automatico_if.sv
// Connection between the game and the automatic player; the game side is the
// master (drives leds and status), the player is the slave (drives botoes).
interface jogador_automatico_if;

  // No valid/ready pair: leds and botoes are level signals sampled every rising
  // edge; a play is a 0 -> one-hot edge on leds, a press is botoes held one-hot.
  logic       habilita;
  logic       inicio;
  logic [3:0] leds;
  logic       ganhou;
  logic       perdeu;
  logic [3:0] botoes;
  logic       ativo;
  logic       erro_captura;
  logic [3:0] db_estado;
  logic [3:0] db_rodada;

  modport master (
    output habilita, inicio, leds, ganhou, perdeu,
    input  botoes, ativo, erro_captura, db_estado, db_rodada
  );

  modport slave (
    input  habilita, inicio, leds, ganhou, perdeu,
    output botoes, ativo, erro_captura, db_estado, db_rodada
  );

endinterface

// File: rtl/jogador_automatico_memoria.sv
// Register file holding the captured plays of the current round: synchronous
// write, asynchronous read, cleared synchronously by reset.
module memoria_jogadas_auto #(
  parameter int N  = 16,
  parameter int AW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_end_esc,
  input  logic [3:0]    i_dado,
  input  logic [AW-1:0] i_end_leit,
  output logic [3:0]    o_dado
);

  logic [3:0] r_mem [N];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_end_esc] <= i_dado;
    end
  end

  assign o_dado = r_mem[i_end_leit];

endmodule

// File: rtl/jogador_automatico.sv
// Automatic player: records the sequence the memory game flashes on leds and
// replays it as timed one-hot button presses, one more play every round.
module jogador_automatico
  import jogador_automatico_pkg::*;
#(
  parameter int MAX_JOGADAS    = 16,
  parameter int PRESS_CYCLES   = 10,
  parameter int RELEASE_CYCLES = 10,
  parameter int QUIET_CYCLES   = 20
) (
  input  logic                 clock,
  input  logic                 reset,
  jogador_automatico_if.slave  bus
);

  localparam int IW   = (MAX_JOGADAS > 1) ? $clog2(MAX_JOGADAS) : 1;
  localparam int CMAX = (PRESS_CYCLES > RELEASE_CYCLES)
                        ? ((PRESS_CYCLES > QUIET_CYCLES) ? PRESS_CYCLES : QUIET_CYCLES)
                        : ((RELEASE_CYCLES > QUIET_CYCLES) ? RELEASE_CYCLES : QUIET_CYCLES);
  localparam int TW   = $clog2(CMAX + 1);

  localparam logic [IW-1:0] ULTIMA_RODADA = IW'(MAX_JOGADAS - 1);
  localparam logic [TW-1:0] T_PRESS       = TW'(PRESS_CYCLES - 1);
  localparam logic [TW-1:0] T_SOLTA       = TW'(RELEASE_CYCLES - 1);
  localparam logic [TW-1:0] T_QUIETO      = TW'(QUIET_CYCLES - 1);

  estado_t       r_estado;
  logic [IW-1:0] r_r;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] r_k;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_botoes;
  logic [3:0]    r_leds_ant;
  logic          r_ativo;
  logic          r_erro;
  logic          r_inicio_ant;
  logic          r_cap_fim;

  logic          w_borda_leds;
  logic          w_borda_inicio;
  logic          w_leds_ruim;
  logic          w_fim_jogo;
  logic          w_em_jogo;
  logic          w_grava;
  logic [IW-1:0] w_end_leit;
  logic [3:0]    w_mem_dado;

  assign w_borda_leds   = (bus.leds != 4'd0) && (r_leds_ant == 4'd0);
  assign w_borda_inicio = bus.inicio && !r_inicio_ant;
  assign w_leds_ruim    = (bus.leds != 4'd0) && !eh_onehot4(bus.leds);
  assign w_fim_jogo     = bus.ganhou || bus.perdeu;
  assign w_em_jogo      = (r_estado != EST_OCIOSO) && (r_estado != EST_FIM);

  // Write only when the FSM really takes the ESPERA_LED -> CAPTURA branch below.
  assign w_grava = bus.habilita && (r_estado == EST_ESPERA_LED) && !w_fim_jogo &&
                   !w_borda_inicio && !w_leds_ruim && w_borda_leds;

  // The press value is loaded on the edge that enters PRESSIONA, so read the
  // address k will hold after that edge: 0 from QUIETO, k+1 from SOLTA.
  assign w_end_leit = (r_estado == EST_SOLTA) ? (r_k + IW'(1)) : '0;

  memoria_jogadas_auto #(
    .N  (MAX_JOGADAS),
    .AW (IW)
  ) u_memoria (
    .clock      (clock),
    .reset      (reset),
    .i_we       (w_grava),
    .i_end_esc  (r_idx),
    .i_dado     (bus.leds),
    .i_end_leit (w_end_leit),
    .o_dado     (w_mem_dado)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado     <= EST_OCIOSO;
      r_r          <= '0;
      r_idx        <= '0;
      r_k          <= '0;
      r_timer      <= '0;
      r_botoes     <= '0;
      r_leds_ant   <= '0;
      r_ativo      <= 1'b0;
      r_erro       <= 1'b0;
      r_inicio_ant <= 1'b0;
      r_cap_fim    <= 1'b0;
    end else begin
      r_leds_ant   <= bus.leds;
      r_inicio_ant <= bus.inicio;
      // Outputs follow the next state: a press only survives where it is re-loaded.
      r_timer      <= '0;
      r_botoes     <= '0;
      r_ativo      <= 1'b1;

      if (!bus.habilita) begin
        r_estado <= EST_OCIOSO;
        r_ativo  <= 1'b0;
      end else if (w_em_jogo && w_fim_jogo) begin
        r_estado <= EST_FIM;
        r_ativo  <= 1'b0;
      end else if (w_em_jogo && w_borda_inicio) begin
        r_estado  <= EST_ESPERA_LED;
        r_r       <= '0;
        r_idx     <= '0;
        r_cap_fim <= 1'b0;
        r_erro    <= 1'b0;
      end else if (w_em_jogo && w_leds_ruim) begin
        r_estado <= EST_FIM;
        r_ativo  <= 1'b0;
        r_erro   <= 1'b1;
      end else begin
        case (r_estado)
          EST_OCIOSO: begin
            if (bus.inicio) begin
              r_estado  <= EST_ESPERA_LED;
              r_r       <= '0;
              r_idx     <= '0;
              r_cap_fim <= 1'b0;
              r_erro    <= 1'b0;
            end else begin
              r_ativo <= 1'b0;
            end
          end
          EST_ESPERA_LED: begin
            if (w_borda_leds) begin
              r_estado  <= EST_CAPTURA;
              r_idx     <= r_idx + IW'(1);
              // Remembers that play r was captured, so idx never needs to hold r+1.
              r_cap_fim <= (r_idx == r_r);
            end
          end
          EST_CAPTURA: begin
            if (bus.leds == 4'd0) begin
              r_estado <= r_cap_fim ? EST_QUIETO : EST_ESPERA_LED;
            end
          end
          EST_QUIETO: begin
            if (bus.leds != 4'd0) begin
              r_estado <= EST_FIM;
              r_ativo  <= 1'b0;
              r_erro   <= 1'b1;
            end else if (r_timer == T_QUIETO) begin
              r_estado <= EST_PRESSIONA;
              r_k      <= '0;
              r_botoes <= w_mem_dado;
            end else begin
              r_timer <= r_timer + TW'(1);
            end
          end
          EST_PRESSIONA: begin
            if (r_timer == T_PRESS) begin
              r_estado <= EST_SOLTA;
            end else begin
              r_timer  <= r_timer + TW'(1);
              r_botoes <= r_botoes;
            end
          end
          EST_SOLTA: begin
            if (r_timer != T_SOLTA) begin
              r_timer <= r_timer + TW'(1);
            end else if (r_k != r_r) begin
              r_estado <= EST_PRESSIONA;
              r_k      <= r_k + IW'(1);
              r_botoes <= w_mem_dado;
            end else if (r_r == ULTIMA_RODADA) begin
              r_estado <= EST_FIM;
              r_ativo  <= 1'b0;
            end else begin
              r_estado  <= EST_ESPERA_LED;
              r_r       <= r_r + IW'(1);
              r_idx     <= '0;
              r_cap_fim <= 1'b0;
            end
          end
          EST_FIM: begin
            if (w_borda_inicio) begin
              r_estado  <= EST_ESPERA_LED;
              r_r       <= '0;
              r_idx     <= '0;
              r_cap_fim <= 1'b0;
              r_erro    <= 1'b0;
            end else begin
              r_ativo <= 1'b0;
              if (w_leds_ruim) r_erro <= 1'b1;
            end
          end
          default: begin
            r_estado <= EST_OCIOSO;
            r_ativo  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.botoes       = r_botoes;
  assign bus.ativo        = r_ativo;
  assign bus.erro_captura = r_erro;
  assign bus.db_estado    = r_estado;
  assign bus.db_rodada    = 4'(r_r);

endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: a small game model flashes random sequences,
// a scoreboard checks every replayed press, then directed corner cases follow.
module tb_jogador_automatico;
  import jogador_automatico_pkg::*;

  localparam int MAXJ  = 16;
  localparam int PRESS = 10;
  localparam int SOLT  = 10;
  localparam int QUIET = 20;

  logic clock = 1'b0;
  logic reset = 1'b1;

  jogador_automatico_if bus_if ();

  jogador_automatico #(
    .MAX_JOGADAS    (MAXJ),
    .PRESS_CYCLES   (PRESS),
    .RELEASE_CYCLES (SOLT),
    .QUIET_CYCLES   (QUIET)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  // ---------------- clock / reset block ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // ---------------- scoreboard state ----------------
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [4:0]  exp_q[$];          // {first play of round, expected button value}
  bit          mon_en = 1'b0;
  int          n_press = 0;
  int          rise_cyc = 0;
  int          fall_cyc = 0;
  int          first_rise_cyc = 0;
  logic [3:0]  seq [MAXJ];

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [3:0] prev_b;
    logic [4:0] e;
    prev_b = 4'd0;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        if (prev_b == 4'd0 && bus_if.botoes != 4'd0) begin
          if (exp_q.size() == 0) begin
            chk("press_unexpected", bus_if.botoes, 0);
          end else begin
            e = exp_q.pop_front();
            chk("press_value", bus_if.botoes, e[3:0]);
            if (e[4]) first_rise_cyc = cyc;
            else chk("release_len", cyc - fall_cyc, SOLT);
          end
          rise_cyc = cyc;
          n_press++;
        end else if (prev_b != 4'd0 && bus_if.botoes == 4'd0) begin
          chk("press_len", cyc - rise_cyc, PRESS);
          fall_cyc = cyc;
        end else if (prev_b != 4'd0 && bus_if.botoes != prev_b) begin
          chk("press_glitch", bus_if.botoes, prev_b);
        end
      end
      prev_b = bus_if.botoes;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_inicio();
    bus_if.inicio = 1'b1;
    tick();
    bus_if.inicio = 1'b0;
  endtask

  // Flashes plays 0..r like the game does; returns the cycle the last led went dark.
  task automatic show_round(input int r, output int c_last);
    for (int i = 0; i <= r; i++) begin
      bus_if.leds = seq[i];
      tick($urandom_range(6, 1));
      bus_if.leds = 4'd0;
      if (i < r) tick($urandom_range(6, 1));
    end
    c_last = cyc;
  endtask

  task automatic wait_estado(input string nome, input logic [3:0] alvo, input int budget);
    int n;
    n = 0;
    while (bus_if.db_estado != alvo && n < budget) begin
      tick();
      n++;
    end
    chk(nome, bus_if.db_estado, alvo);
  endtask

  task automatic wait_presses(input int alvo, input int budget);
    int n;
    n = 0;
    while (n_press < alvo && n < budget) begin
      tick();
      n++;
    end
    chk("presses_seen", n_press, alvo);
  endtask

  task automatic flash_one(input logic [3:0] v);
    bus_if.leds = v;
    tick(2);
    bus_if.leds = 4'd0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c_last;
    int base;
    bus_if.habilita = 1'b0;
    bus_if.inicio   = 1'b0;
    bus_if.leds     = 4'd0;
    bus_if.ganhou   = 1'b0;
    bus_if.perdeu   = 1'b0;

    tick(3);
    chk("rst_botoes", bus_if.botoes, 0);
    chk("rst_ativo", bus_if.ativo, 0);
    chk("rst_erro", bus_if.erro_captura, 0);
    chk("rst_estado", bus_if.db_estado, OCIOSO);
    chk("rst_rodada", bus_if.db_rodada, 0);
    reset = 1'b0;
    bus_if.habilita = 1'b1;
    tick(2);
    chk("idle_no_inicio", bus_if.db_estado, OCIOSO);

    // Full game to the round limit; the first two plays follow the documented example.
    seq[0] = 4'b0001;
    seq[1] = 4'b0100;
    for (int i = 2; i < MAXJ; i++) seq[i] = 4'(1 << $urandom_range(3, 0));
    mon_en = 1'b1;
    pulse_inicio();
    chk("start_estado", bus_if.db_estado, ESPERA_LED);
    chk("start_ativo", bus_if.ativo, 1);
    for (int r = 0; r < MAXJ; r++) begin
      for (int i = 0; i <= r; i++) exp_q.push_back({(i == 0), seq[i]});
      base = n_press;
      show_round(r, c_last);
      wait_presses(base + r + 1, (r + 1) * (PRESS + SOLT + 2) + QUIET + 20);
      // One cycle ends the capture, then QUIET dark cycles precede the first press.
      chk("quiet_delay", first_rise_cyc - c_last, QUIET + 1);
      if (r < MAXJ - 1) begin
        wait_estado("round_end", ESPERA_LED, PRESS + SOLT + 20);
        chk("db_rodada", bus_if.db_rodada, r + 1);
        chk("ativo_round", bus_if.ativo, 1);
      end else begin
        wait_estado("game_limit", FIM, PRESS + SOLT + 20);
        chk("limit_botoes", bus_if.botoes, 0);
        chk("limit_ativo", bus_if.ativo, 0);
        chk("limit_erro", bus_if.erro_captura, 0);
        chk("limit_rodada", bus_if.db_rodada, MAXJ - 1);
      end
    end
    chk("queue_drained", exp_q.size(), 0);
    mon_en = 1'b0;
    tick(3);

    // Malformed leds while waiting for a play.
    pulse_inicio();
    chk("restart_rodada", bus_if.db_rodada, 0);
    chk("restart_estado", bus_if.db_estado, ESPERA_LED);
    bus_if.leds = 4'b0101;
    tick();
    chk("bad_leds_erro", bus_if.erro_captura, 1);
    chk("bad_leds_estado", bus_if.db_estado, FIM);
    chk("bad_leds_botoes", bus_if.botoes, 0);
    bus_if.leds = 4'd0;
    tick(5);
    chk("erro_sticky", bus_if.erro_captura, 1);
    chk("fim_botoes", bus_if.botoes, 0);

    // Restart clears the error; perdeu in the middle of a press ends the game.
    pulse_inicio();
    chk("clear_erro", bus_if.erro_captura, 0);
    chk("clear_rodada", bus_if.db_rodada, 0);
    chk("clear_estado", bus_if.db_estado, ESPERA_LED);
    bus_if.leds = 4'b0100;
    tick(3);
    bus_if.leds = 4'd0;
    wait_estado("reach_press", PRESSIONA, QUIET + 10);
    chk("press_0100", bus_if.botoes, 4'b0100);
    tick(3);
    bus_if.perdeu = 1'b1;
    tick();
    chk("perdeu_estado", bus_if.db_estado, FIM);
    chk("perdeu_botoes", bus_if.botoes, 0);
    chk("perdeu_ativo", bus_if.ativo, 0);
    bus_if.perdeu = 1'b0;

    // habilita low during a release.
    pulse_inicio();
    flash_one(4'b0010);
    wait_estado("reach_solta", SOLTA, QUIET + PRESS + 10);
    tick(3);
    bus_if.habilita = 1'b0;
    tick();
    chk("hab_estado", bus_if.db_estado, OCIOSO);
    chk("hab_ativo", bus_if.ativo, 0);
    chk("hab_botoes", bus_if.botoes, 0);
    bus_if.habilita = 1'b1;
    tick(2);
    chk("hab_stays_idle", bus_if.db_estado, OCIOSO);

    // inicio while counting the quiet period restarts from round 0.
    pulse_inicio();
    flash_one(4'b0001);
    wait_estado("reach_quieto", QUIETO, 10);
    tick(4);
    pulse_inicio();
    chk("inicio_quieto_estado", bus_if.db_estado, ESPERA_LED);
    chk("inicio_quieto_rodada", bus_if.db_rodada, 0);

    // An extra play during the quiet period is a capture error.
    flash_one(4'b0001);
    wait_estado("reach_quieto2", QUIETO, 10);
    tick(3);
    bus_if.leds = 4'b0010;
    tick();
    chk("extra_erro", bus_if.erro_captura, 1);
    chk("extra_estado", bus_if.db_estado, FIM);
    bus_if.leds = 4'd0;

    // ganhou during a capture.
    pulse_inicio();
    bus_if.leds = 4'b1000;
    tick(2);
    chk("ganhou_pre", bus_if.db_estado, CAPTURA);
    bus_if.ganhou = 1'b1;
    tick();
    chk("ganhou_estado", bus_if.db_estado, FIM);
    chk("ganhou_ativo", bus_if.ativo, 0);
    bus_if.ganhou = 1'b0;
    bus_if.leds   = 4'd0;

    // Synchronous reset during a press.
    pulse_inicio();
    flash_one(4'b1000);
    wait_estado("reach_press2", PRESSIONA, QUIET + 10);
    chk("press_1000", bus_if.botoes, 4'b1000);
    tick(2);
    reset = 1'b1;
    tick();
    chk("srst_botoes", bus_if.botoes, 0);
    chk("srst_ativo", bus_if.ativo, 0);
    chk("srst_erro", bus_if.erro_captura, 0);
    chk("srst_estado", bus_if.db_estado, OCIOSO);
    chk("srst_rodada", bus_if.db_rodada, 0);
    reset = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
